// File: rtl/bus_capture.sv
// bus_capture: gated-bus capture buffer, DEPTH-entry circular queue
// with valid/ready drain and a sticky overflow flag for dropped loads.
module bus_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         load,
  output logic [WIDTH-1:0]             out,
  output logic                         valid,
  input  logic                         ready,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             wr;
  logic             pop;
  logic             drop;

  // full comes from the registered count, so drop uses pre-edge state
  assign full  = (cnt == CMAX);
  assign valid = (cnt != '0);
  assign empty = ~valid;
  assign count = cnt;
  assign overflow = ovf;

  assign wr   = load & ~full;
  assign drop = load & full;
  assign pop  = valid & ready;

  assign out = mem[rptr] & {WIDTH{valid}};

  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mem[wptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case (1'b1)
        (wr & ~pop): cnt <= cnt + 1'b1;
        (pop & ~wr): cnt <= cnt - 1'b1;
        default:     cnt <= cnt;
      endcase
      // a drop on the same edge as a clear leaves the flag set
      if (drop) begin
        ovf <= 1'b1;
      end else if (clear_overflow) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_capture.sv
// tb_bus_capture: directed vectors with hand-computed expectations
// for bus_capture at WIDTH=8, DEPTH=4.
module tb_bus_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       load;
  logic [7:0] out;
  logic       valid;
  logic       ready;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int failures = 0;

  bus_capture #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .in(din),
    .load(load),
    .out(out),
    .valid(valid),
    .ready(ready),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("empty_inv", {31'd0, empty}, {31'd0, ~valid});
  endtask

  task automatic push(input logic [7:0] v);
    load = 1'b1;
    din  = v;
    step();
    load = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] o,
                              input logic [2:0] c, input logic ov);
    check({tag, "_out"}, {24'd0, out}, {24'd0, o});
    check({tag, "_cnt"}, {29'd0, count}, {29'd0, c});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
    check({tag, "_full"}, {31'd0, full}, {31'd0, c == 3'd4});
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] o,
                            input logic [2:0] c, input logic ov);
    expect_state(tag, o, c, ov);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    din = 8'h00;
    load = 1'b0;
    ready = 1'b0;
    clear_overflow = 1'b0;
    step();
    reset = 1'b0;
    expect_state("rst", 8'h00, 3'd0, 1'b0);
    check("rst_empty", {31'd0, empty}, 32'd1);

    // single capture latency
    push(8'hA5);
    expect_state("a5", 8'hA5, 3'd1, 1'b0);
    check("a5_valid", {31'd0, valid}, 32'd1);
    pop_expect("a5_pop", 8'hA5, 3'd1, 1'b0);
    expect_state("a5_end", 8'h00, 3'd0, 1'b0);

    // fill, overflow, drain in order
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    expect_state("fill4", 8'h11, 3'd4, 1'b0);
    push(8'h55);
    expect_state("drop55", 8'h11, 3'd4, 1'b1);
    pop_expect("d1", 8'h11, 3'd4, 1'b1);
    pop_expect("d2", 8'h22, 3'd3, 1'b1);
    pop_expect("d3", 8'h33, 3'd2, 1'b1);
    pop_expect("d4", 8'h44, 3'd1, 1'b1);
    expect_state("drained", 8'h00, 3'd0, 1'b1);
    check("drained_empty", {31'd0, empty}, 32'd1);

    // ready while empty is ignored
    ready = 1'b1;
    step();
    ready = 1'b0;
    expect_state("rdy_empty", 8'h00, 3'd0, 1'b1);

    // clear, then clear colliding with a drop
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    clear_overflow = 1'b1;
    push(8'hBB);
    clear_overflow = 1'b0;
    expect_state("clr_drop", 8'hA1, 3'd4, 1'b1);
    pop_expect("a1", 8'hA1, 3'd4, 1'b1);
    pop_expect("a2", 8'hA2, 3'd3, 1'b1);
    pop_expect("a3", 8'hA3, 3'd2, 1'b1);
    pop_expect("a4", 8'hA4, 3'd1, 1'b1);
    expect_state("a_end", 8'h00, 3'd0, 1'b1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;

    // simultaneous write and pop at count=2
    push(8'h01);
    push(8'h02);
    ready = 1'b1;
    push(8'h77);
    ready = 1'b0;
    expect_state("wp", 8'h02, 3'd2, 1'b0);
    pop_expect("wp1", 8'h02, 3'd2, 1'b0);
    pop_expect("wp2", 8'h77, 3'd1, 1'b0);
    expect_state("wp_end", 8'h00, 3'd0, 1'b0);

    // load while full with a pop on the same edge is still dropped
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    ready = 1'b1;
    push(8'h99);
    ready = 1'b0;
    expect_state("fp", 8'hC2, 3'd3, 1'b1);
    pop_expect("c2", 8'hC2, 3'd3, 1'b1);
    pop_expect("c3", 8'hC3, 3'd2, 1'b1);
    pop_expect("c4", 8'hC4, 3'd1, 1'b1);
    expect_state("c_end", 8'h00, 3'd0, 1'b1);

    // mid-operation reset at count=3 with overflow set
    push(8'hE1);
    push(8'hE2);
    push(8'hE3);
    ready = 1'b1;
    push(8'hE4);
    ready = 1'b0;
    expect_state("pre_rst", 8'hE2, 3'd3, 1'b1);
    reset = 1'b1;
    ready = 1'b1;
    clear_overflow = 1'b0;
    push(8'hFF);
    reset = 1'b0;
    ready = 1'b0;
    expect_state("mid_rst", 8'h00, 3'd0, 1'b0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);

    // eight write/read pairs walk both pointers around twice
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h10 + 8'(i * 17);
      push(v);
      expect_state($sformatf("wrap%0d", i), v, 3'd1, 1'b0);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check($sformatf("wrap%0d_e", i), {31'd0, empty}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
